dbus_mem_bridge: RTL

Sits directly downstream of the load/store unit on the data bus (dbus). Takes the LSU's level-held load/store request and runs one transaction on a request/grant/response memory port. Stores get byte enables and lane-replicated write data. Each request is answered with a one-cycle ack plus read data or an error; flush, misalignment and bus timeout are handled inside the block.

---
 rtl/dbus_pkg.sv | 13 +
 rtl/mem_defs.sv | 11 +
 rtl/dbus_wr_align.sv | 36 +++
 rtl/dbus_mem_bridge.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Data-bus bridge types and defaults.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } type_dbus_state_e;

  localparam int unsigned DBUS_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_defs.sv
// Memory-side definitions shared across the load/store path.
package mem_defs;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } type_st_ops_e;

endpackage

// File: rtl/dbus_wr_align.sv
// Store lane steering: byte enables, replicated write data and misalignment detection.
module dbus_wr_align
  import mem_defs::*;
(
  input  logic [1:0]   addr_lo,
  input  type_st_ops_e st_ops,
  input  logic [31:0]  w_data,
  output logic [3:0]   be,
  output logic [31:0]  wdata,
  output logic         misaligned
);

  always_comb begin
    be         = '0;
    wdata      = '0;
    misaligned = 1'b0;
    case (st_ops)
      ST_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{w_data[7:0]}};
      end
      ST_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{w_data[15:0]}};
        misaligned = addr_lo[0];
      end
      ST_SW: begin
        be         = 4'b1111;
        wdata      = w_data;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_mem_bridge.sv
// Bridges the LSU's level-held load/store request onto a req/gnt/rvalid memory port,
// answering each request with a single-cycle ack plus read data or an error.
module dbus_mem_bridge
  import dbus_pkg::*, mem_defs::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_ld_req_i,
  input  logic              lsu_st_req_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_w_data_i,
  input  logic [1:0]        lsu_st_ops_i,
  input  logic              lsu_flush_i,
  output logic              dbus_ack_o,
  output logic [DATA_W-1:0] dbus_r_data_o,
  output logic              dbus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  type_dbus_state_e  state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              drain;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic              al_mis;
  logic              req_go;
  logic              st_mis;
  logic              timeout;
  logic              discard;

  dbus_wr_align u_wr_align (
    .addr_lo    (lsu_addr_i[1:0]),
    .st_ops     (type_st_ops_e'(lsu_st_ops_i)),
    .w_data     (lsu_w_data_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis)
  );

  assign req_go  = (lsu_ld_req_i | lsu_st_req_i) & ~lsu_flush_i;
  assign st_mis  = lsu_st_req_i & al_mis;
  assign timeout = (cnt == CNT_LAST);
  // A flushed transaction that already holds a grant must still swallow its response.
  assign discard = drain | lsu_flush_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_go) state_nxt = st_mis ? DONE : REQ;
      REQ: begin
        if (lsu_flush_i)    state_nxt = mem_gnt_i ? RESP : IDLE;
        else if (timeout)   state_nxt = DONE;
        else if (mem_gnt_i) state_nxt = RESP;
      end
      RESP: if (mem_rvalid_i || timeout) state_nxt = discard ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = 1'b0;
    dbus_ack_o = 1'b0;
    case (state)
      REQ:     mem_req_o  = 1'b1;
      DONE:    dbus_ack_o = ~lsu_flush_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      drain   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_go) begin
          cnt     <= '0;
          drain   <= 1'b0;
          we_q    <= lsu_st_req_i;
          addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
          be_q    <= lsu_st_req_i ? al_be : 4'b1111;
          wdata_q <= lsu_st_req_i ? al_wdata : '0;
          err_q   <= st_mis;
          if (st_mis) rdata_q <= '0;
        end
        REQ, RESP: begin
          cnt   <= cnt + 1'b1;
          drain <= discard;
          if (state_nxt == DONE) begin
            if (state == RESP && mem_rvalid_i) begin
              err_q   <= mem_err_i;
              rdata_q <= we_q ? '0 : mem_rdata_i;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_err_o    = dbus_ack_o & err_q;
  assign dbus_r_data_o = rdata_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_be_o      = be_q;
  assign mem_wdata_o   = wdata_q;

endmodule
